llr_frame_loader: RTL and testbench
===================================

Name: llr_frame_loader

Overview:
- Upstream stage of the 8-bit SC polar decoder. Accepts channel LLRs serially as two's-complement words over a valid/ready handshake.
- Converts each LLR to the decoder's sign-magnitude format (MSB = sign, low BT-1 bits = magnitude) and packs N of them into one BT*N-bit frame.
- Presents each frame to the decoder with a valid/ack handshake. A ping-pong arrangement (fill buffer plus output register) lets frame k+1 load while the decoder works on frame k.

Parameters:
- BT, 16, LLR width in bits (input two's complement and output sign-magnitude).
- N, 8, LLRs per frame (code length).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- llr_in  in  BT  channel LLR, two's complement
- llr_valid  in  1  llr_in is valid this cycle
- llr_ready  out  1  loader can accept a sample this cycle
- frame_out  out  BT*N  packed sign-magnitude frame; first-received LLR in bits [BT*N-1 : BT*(N-1)], last in [BT-1:0]
- frame_valid  out  1  frame_out holds an unconsumed frame
- frame_ack  in  1  decoder has taken frame_out (single-cycle pulse)
- frame_sat  out  1  at least one LLR in frame_out was saturated during conversion

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - fill count = 0, fill_full = 0, frame_valid = 0, frame_out = 0, frame_sat = 0, internal saturation accumulator = 0.
  - A frame that is partially filled or pending is discarded.
- Conversion, combinational on llr_in:
  - llr_in >= 0: out = llr_in.
  - llr_in < 0, excluding the most-negative value: out = {1, |llr_in|}.
  - llr_in = -2^(BT-1) (0x8000): out = 0xFFFF (magnitude saturates to 2^(BT-1)-1) and the sample counts as saturated.
  - Negative zero is never produced; 0 maps to 0x0000.
- Accept: a transfer occurs when llr_valid && llr_ready. The converted word is written to fill slot[cnt], cnt increments, and the saturation accumulator ORs in this sample's flag.
- cnt wrap: when the accepted sample is number N (cnt = N-1), set fill_full = 1 and cnt = 0.
- llr_ready = !fill_full. This is combinational from state only and never depends on llr_valid.
- Frame transfer fires when fill_full && (!frame_valid || frame_ack). Next edge:
  - frame_out <= fill buffer
  - frame_sat <= accumulator
  - frame_valid <= 1
  - fill_full <= 0
  - accumulator <= 0
- Latency: if the output register is free, frame_valid rises on the edge after the Nth sample is accepted, i.e. 1 cycle after the last handshake. Back-to-back streaming gives N+1 cycles for the first frame.
- Release: frame_ack && frame_valid with no transfer in the same cycle -> frame_valid <= 0. frame_ack while frame_valid = 0 is ignored.
- Simultaneous ack and transfer: frame_valid stays 1 and frame_out is replaced. No bubble cycle.
- Hold: while frame_valid = 1, frame_out and frame_sat are stable until ack. The decoder reads frame_out in its load state.
- Backpressure: with the fill buffer full and the output frame unacked, llr_ready = 0. Samples presented then are not taken, and the source must hold them.
- Throughput: up to 1 LLR per cycle. llr_ready deasserts for exactly 1 cycle between frames when the output register is free.

Decomposition:
- Shared package: BT, N, and the sign-magnitude helpers (SIGN_BIT index, MAG_MAX = 2^(BT-1)-1). The decoder's g/f stages use the same helpers.
- One sub-module: llr_tc2sm, the combinational two's-complement to sign-magnitude converter with saturation flag output. Reusable anywhere LLRs enter the sign-magnitude domain.

Test Plan:
- Reset, then stream 8 samples {5, -5, 0, 32767, -1, 100, -100, 7} back to back -> frame_valid high 1 cycle after the 8th handshake; frame_out = 0x0005_8005_0000_7FFF_8001_0064_8064_0007; frame_sat = 0.
- Frame containing -32768 (0x8000) in slot 3 -> slot 3 = 0xFFFF, frame_sat = 1. The next frame without it -> frame_sat = 0.
- Two full frames with frame_ack held low -> second frame fills, then llr_ready = 0 and the 17th sample is held. Pulse ack -> second frame appears the next cycle and llr_ready returns to 1.
- frame_ack pulsed on the same cycle a transfer fires -> frame_valid stays 1 continuously and frame_out updates to the new frame.
- rst_n low for 1 cycle after 5 samples of a frame -> all outputs 0. The next 8 samples form a clean frame, with the first post-reset sample in the top slot.
- Random llr_valid gaps (about 50% duty) over 100 frames against a reference model -> every frame_out matches and no sample is lost or duplicated.

Source files
------------

// File: rtl/llr_frame_loader_pkg.sv
// Shared constants and sign-magnitude helpers for the SC polar decoder datapath.
// The g/f stages use the same helpers so every stage agrees on the word layout.
package llr_frame_loader_pkg;

  localparam int unsigned BT       = 16;
  localparam int unsigned N        = 8;
  localparam int unsigned SIGN_BIT = BT - 1;
  localparam logic [BT-1:0] MAG_MAX = {1'b0, {(BT - 1){1'b1}}};

  function automatic logic sm_sign(input logic [BT-1:0] w);
    return w[SIGN_BIT];
  endfunction

  function automatic logic [BT-2:0] sm_mag(input logic [BT-1:0] w);
    return w[BT-2:0];
  endfunction

endpackage

// File: rtl/llr_tc2sm.sv
// Combinational two's-complement to sign-magnitude converter.
// The most-negative input has no sign-magnitude image, so it saturates and raises sat_o.
module llr_tc2sm #(
  parameter int unsigned BT = llr_frame_loader_pkg::BT
) (
  input  logic [BT-1:0] tc_i,
  output logic [BT-1:0] sm_o,
  output logic          sat_o
);
  import llr_frame_loader_pkg::*;

  logic [BT-1:0] neg;

  always_comb begin
    neg   = -tc_i;
    sm_o  = tc_i;
    sat_o = 1'b0;
    if (tc_i[BT-1]) begin
      if (tc_i[BT-2:0] == '0) begin
        sm_o  = '1;
        sat_o = 1'b1;
      end else begin
        sm_o = {1'b1, neg[BT-2:0]};
      end
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Serial LLR loader: converts to sign-magnitude and packs N LLRs per frame, with a
// fill buffer feeding an output register so the next frame loads while the decoder works.
module llr_frame_loader #(
  parameter int unsigned BT = llr_frame_loader_pkg::BT,
  parameter int unsigned N  = llr_frame_loader_pkg::N
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [BT-1:0]   llr_in_i,
  input  logic            llr_valid_i,
  output logic            llr_ready_o,
  output logic [BT*N-1:0] frame_out_o,
  output logic            frame_valid_o,
  input  logic            frame_ack_i,
  output logic            frame_sat_o
);
  import llr_frame_loader_pkg::*;

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] SlotMax = CntW'(N - 1);

  logic [N-1:0][BT-1:0] fill_q, fill_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 acc_q, acc_d;
  logic [BT*N-1:0]      frame_q, frame_d;
  logic                 fv_q, fv_d;
  logic                 fsat_q, fsat_d;

  logic [BT-1:0] sm;
  logic          sat;
  logic          accept;
  logic          xfer;

  llr_tc2sm #(
    .BT (BT)
  ) u_tc2sm (
    .tc_i  (llr_in_i),
    .sm_o  (sm),
    .sat_o (sat)
  );

  assign llr_ready_o = ~full_q;
  assign accept      = llr_valid_i & ~full_q;
  assign xfer        = full_q & (~fv_q | frame_ack_i);

  always_comb begin
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    acc_d   = acc_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    fsat_d  = fsat_q;
    // First-received sample lands in the most significant slot.
    if (accept) begin
      fill_d[SlotMax - cnt_q] = sm;
      acc_d                   = acc_q | sat;
      if (cnt_q == SlotMax) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // accept and xfer are mutually exclusive: one needs full_q low, the other high.
    if (xfer) begin
      frame_d = fill_q;
      fsat_d  = acc_q;
      fv_d    = 1'b1;
      full_d  = 1'b0;
      acc_d   = 1'b0;
    end else if (frame_ack_i && fv_q) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      acc_q   <= 1'b0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      fsat_q  <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      fsat_q  <= fsat_d;
    end
  end

  assign frame_out_o   = frame_q;
  assign frame_valid_o = fv_q;
  assign frame_sat_o   = fsat_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// Bench for llr_frame_loader: directed scenarios plus randomized streaming against
// an arithmetic reference model of the conversion and frame packing.
module tb_llr_frame_loader;

  localparam int unsigned BT = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned FW = BT * N;

  logic          clk;
  logic          rst_n;
  logic [BT-1:0] llr_in;
  logic          llr_valid;
  logic          llr_ready;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ack;
  logic          frame_sat;

  int n_checks;
  int n_pass;

  llr_frame_loader #(
    .BT (BT),
    .N  (N)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .llr_in_i      (llr_in),
    .llr_valid_i   (llr_valid),
    .llr_ready_o   (llr_ready),
    .frame_out_o   (frame_out),
    .frame_valid_o (frame_valid),
    .frame_ack_i   (frame_ack),
    .frame_sat_o   (frame_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference conversion written from the numeric rule, not the bit manipulation.
  function automatic logic [BT-1:0] conv(input logic [BT-1:0] w);
    int v;
    v = int'($signed(w));
    if (v >= 0) return w;
    if (v == -32768) return 16'hFFFF;
    return 16'h8000 | 16'(-v);
  endfunction

  function automatic logic [FW-1:0] pack(input logic [BT-1:0] s [N]);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f = (f << BT) | FW'(conv(s[i]));
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Presents one sample and returns #1 after the edge that accepted it.
  task automatic send(input logic [BT-1:0] v);
    int guard;
    guard     = 0;
    llr_in    = v;
    llr_valid = 1'b1;
    while (!llr_ready && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) check("send_timeout", 1'b0, 1'b1);
    tick();
    llr_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!frame_valid && guard < 50) begin
      tick();
      guard++;
    end
    check(tag, frame_valid, 1'b1);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  logic [BT-1:0] s1 [N] = '{16'd5, 16'hFFFB, 16'd0, 16'd32767, 16'hFFFF, 16'd100, 16'hFF9C, 16'd7};
  logic [BT-1:0] fa [N];
  logic [BT-1:0] fb [N];

  logic [FW-1:0] exp_q [$];
  logic          exp_sat_q [$];
  int            rand_frames_seen;
  bit            drv_done;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    llr_in    = '0;
    llr_valid = 1'b0;
    frame_ack = 1'b0;
    tick();
    do_reset();
    check("rst_valid", frame_valid, 1'b0);
    check("rst_out", frame_out, '0);
    check("rst_sat", frame_sat, 1'b0);
    check("rst_ready", llr_ready, 1'b1);

    // Directed frame with mixed signs.
    for (int i = 0; i < N; i++) send(s1[i]);
    check("lat_not_yet", frame_valid, 1'b0);
    check("bubble_ready", llr_ready, 1'b0);
    tick();
    check("lat_valid", frame_valid, 1'b1);
    check("f1_out", frame_out, 128'h0005_8005_0000_7FFF_8001_0064_8064_0007);
    check("f1_model", frame_out, pack(s1));
    check("f1_sat", frame_sat, 1'b0);
    check("ready_back", llr_ready, 1'b1);
    pulse_ack();
    check("ack_release", frame_valid, 1'b0);

    // Saturating frame, then a clean one.
    for (int i = 0; i < N; i++) fa[i] = (i == 3) ? 16'h8000 : 16'(i * 3 + 1);
    for (int i = 0; i < N; i++) send(fa[i]);
    wait_valid("sat_wait");
    check("sat_slot3", frame_out[FW-1-3*BT -: BT], 16'hFFFF);
    check("sat_frame", frame_out, pack(fa));
    check("sat_flag", frame_sat, 1'b1);
    pulse_ack();
    for (int i = 0; i < N; i++) fb[i] = 16'hFF00 + 16'(i);
    for (int i = 0; i < N; i++) send(fb[i]);
    wait_valid("nosat_wait");
    check("nosat_frame", frame_out, pack(fb));
    check("nosat_flag", frame_sat, 1'b0);

    // Backpressure: frame fb unacked, fill frame fa, then 17th sample is held.
    for (int i = 0; i < N; i++) send(fa[i]);
    llr_in    = 16'h1234;
    llr_valid = 1'b1;
    tick();
    tick();
    check("bp_ready", llr_ready, 1'b0);
    check("bp_hold", frame_out, pack(fb));
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("bp_valid", frame_valid, 1'b1);
    check("bp_new", frame_out, pack(fa));
    check("bp_sat", frame_sat, 1'b1);
    check("bp_ready_back", llr_ready, 1'b1);
    tick();
    llr_valid = 1'b0;
    for (int i = 1; i < N; i++) send(16'(i));
    // Ack on the exact cycle the transfer fires.
    check("sim_pre_valid", frame_valid, 1'b1);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("sim_valid", frame_valid, 1'b1);
    check("sim_out", frame_out, 128'h1234_0001_0002_0003_0004_0005_0006_0007);

    // Reset partway through a frame.
    pulse_ack();
    for (int i = 0; i < 5; i++) send(16'hAAAA);
    do_reset();
    check("mid_rst_valid", frame_valid, 1'b0);
    check("mid_rst_out", frame_out, '0);
    check("mid_rst_sat", frame_sat, 1'b0);
    check("mid_rst_ready", llr_ready, 1'b1);
    for (int i = 0; i < N; i++) send(s1[i]);
    wait_valid("post_rst_wait");
    check("post_rst_frame", frame_out, pack(s1));
    pulse_ack();

    // Randomized streaming with gaps on both sides.
    rand_frames_seen = 0;
    drv_done         = 1'b0;
    fork
      begin : driver
        logic [BT-1:0] cur [N];
        logic [BT-1:0] r;
        logic          sat;
        for (int f = 0; f < 100; f++) begin
          sat = 1'b0;
          for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 1) == 1) tick();
            r = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            cur[i] = r;
            sat    = sat | (r == 16'h8000);
            send(r);
          end
          exp_q.push_back(pack(cur));
          exp_sat_q.push_back(sat);
        end
        drv_done = 1'b1;
      end
      begin : consumer
        int budget;
        budget = 0;
        while (rand_frames_seen < 100 && budget < 20000) begin
          if (frame_valid && $urandom_range(0, 1) == 1) begin
            if (exp_q.size() == 0) begin
              check("rand_extra", 1'b1, 1'b0);
            end else begin
              check("rand_frame", frame_out, exp_q.pop_front());
              check("rand_sat", frame_sat, exp_sat_q.pop_front());
            end
            rand_frames_seen++;
            frame_ack = 1'b1;
          end
          tick();
          frame_ack = 1'b0;
          budget++;
        end
      end
    join
    check("rand_count", 32'(rand_frames_seen), 32'd100);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_drv_done", drv_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
